// File: rtl/rx_handshake_sequencer.sv
// Receive-side transaction sequencer: arms the receiver after each sent packet, classifies
// the handshake response, retries on NAK/timeout/bad data, and reports one result per transaction.
module rx_handshake_sequencer #(
   parameter  int TIMEOUT   = 255,
   parameter  int MAX_RETRY = 3,
   localparam int TO_W      = $clog2(TIMEOUT),
   localparam int RT_W      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1)
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            xact_start,
   input  logic            xact_is_in,
   input  logic            abort,
   input  logic            tx_done,
   input  logic            rec_ACK,
   input  logic            rec_NAK,
   input  logic            rec_DATA0,
   input  logic            data_valid,
   input  logic [63:0]     data_rec,
   output logic            rec_start,
   output logic            resend,
   output logic            busy,
   output logic            xact_done,
   output logic            xact_ok,
   output logic            xact_fail,
   output logic [63:0]     data_out,
   output logic [RT_W-1:0] retry_cnt
);

   typedef enum logic [1:0] {IDLE, WAIT_TX, LISTEN, RETRY} state_t;

   state_t          state, next_state;
   logic            dir, next_dir;
   logic [TO_W-1:0] timer, next_timer;
   logic [RT_W-1:0] next_retry;
   logic [63:0]     next_data;
   logic            next_rec_start, next_resend, next_done, next_ok, next_fail;
   logic            go_retry, go_ok, go_abort;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         dir       <= 1'b0;
         timer     <= '0;
         rec_start <= 1'b0;
         resend    <= 1'b0;
         busy      <= 1'b0;
         xact_done <= 1'b0;
         xact_ok   <= 1'b0;
         xact_fail <= 1'b0;
         data_out  <= '0;
         retry_cnt <= '0;
      end else begin
         state     <= next_state;
         dir       <= next_dir;
         timer     <= next_timer;
         rec_start <= next_rec_start;
         resend    <= next_resend;
         busy      <= (next_state != IDLE);
         xact_done <= next_done;
         xact_ok   <= next_ok;
         xact_fail <= next_fail;
         data_out  <= next_data;
         retry_cnt <= next_retry;
      end
   end

   // Outputs are computed one cycle ahead so every port comes straight from a flop.
   always_comb begin
      next_state     = state;
      next_dir       = dir;
      next_timer     = timer;
      next_retry     = retry_cnt;
      next_data      = data_out;
      next_rec_start = 1'b0;
      next_resend    = 1'b0;
      next_done      = 1'b0;
      next_ok        = 1'b0;
      next_fail      = 1'b0;
      go_retry       = 1'b0;
      go_ok          = 1'b0;
      go_abort       = 1'b0;

      case (state)
         IDLE: begin
            if (xact_start) begin
               next_dir   = xact_is_in;
               next_retry = '0;
               next_state = WAIT_TX;
            end
         end
         WAIT_TX: begin
            if (abort) begin
               go_abort = 1'b1;
            end else if (tx_done) begin
               next_state     = LISTEN;
               next_rec_start = 1'b1;
               next_timer     = '0;
            end
         end
         LISTEN: begin
            next_timer = timer + TO_W'(1);
            if (abort) begin
               go_abort = 1'b1;
            end else if (rec_ACK) begin
               go_ok    = !dir;
               go_retry = dir;
            end else if (rec_NAK) begin
               go_retry = 1'b1;
            end else if (rec_DATA0) begin
               go_ok    = dir && data_valid;
               go_retry = !(dir && data_valid);
            end else if (timer == TO_W'(TIMEOUT - 1)) begin
               go_retry = 1'b1;
            end
         end
         RETRY: begin
            if (abort) begin
               go_abort = 1'b1;
            end else begin
               next_state = WAIT_TX;
            end
         end
         default: next_state = IDLE;
      endcase

      // Exhausted retries report failure directly instead of pulsing resend.
      if (go_retry) begin
         if (retry_cnt == RT_W'(MAX_RETRY)) begin
            next_state = IDLE;
            next_done  = 1'b1;
            next_fail  = 1'b1;
         end else begin
            next_state  = RETRY;
            next_resend = 1'b1;
            next_retry  = retry_cnt + RT_W'(1);
         end
      end

      if (go_ok) begin
         next_state = IDLE;
         next_done  = 1'b1;
         next_ok    = 1'b1;
         if (dir) begin
            next_data = data_rec;
         end
      end

      if (go_abort) begin
         next_state = IDLE;
         next_done  = 1'b1;
         next_fail  = 1'b1;
      end
   end

endmodule
